// File: rtl/decoder_pipe_pkg.sv
// rtl/decoder_pipe_pkg.sv - shared defaults and occupancy state type for decoder_pipe
// Package dec_pkg: default select/output widths and the storage occupancy enum.
package dec_pkg;

    localparam int DEC_SEL_W_DEF   = 3;
    localparam int DEC_NUM_OUT_DEF = 8;

    // Occupancy of the output storage: nothing, main reg only, main + skid.
    typedef enum logic [1:0] {
        DEC_EMPTY = 2'd0,
        DEC_ONE   = 2'd1,
        DEC_FULL  = 2'd2
    } dec_occ_e;

endpackage

// File: rtl/decoder_pipe_if.sv
// rtl/decoder_pipe_if.sv - valid/ready bundle between upstream, decoder_pipe and downstream
// Signals: in_valid/in_ready/in_sel/in_en (input beat), out_valid/out_ready/out_onehot
// (output beat), out_err only when DEC_RANGE_CHK_EN is defined.
// Modports: master = the environment around the decoder, slave = decoder_pipe.
interface decoder_pipe_if
    import dec_pkg::*;
#(
    parameter int SEL_W   = DEC_SEL_W_DEF,
    parameter int NUM_OUT = DEC_NUM_OUT_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_en;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_onehot;
`ifdef DEC_RANGE_CHK_EN
    logic               out_err;
`endif

    modport master (
        output in_valid, in_sel, in_en, out_ready,
        input  in_ready, out_valid, out_onehot
`ifdef DEC_RANGE_CHK_EN
        , input out_err
`endif
    );

    modport slave (
        input  in_valid, in_sel, in_en, out_ready,
        output in_ready, out_valid, out_onehot
`ifdef DEC_RANGE_CHK_EN
        , output out_err
`endif
    );

endinterface

// File: rtl/decoder_pipe_onehot_dec.sv
// rtl/decoder_pipe_onehot_dec.sv - combinational SEL_W-to-NUM_OUT one-hot decoder
// Ports: sel (index), en (enable) -> onehot (NUM_OUT bits, zero when disabled or
// out of range), err (only with DEC_RANGE_CHK_EN: en and sel >= NUM_OUT).
module onehot_dec #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] onehot
`ifdef DEC_RANGE_CHK_EN
    ,
    output logic               err
`endif
);

    // Indices at or above NUM_OUT match no bit, so out-of-range selects give zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

`ifdef DEC_RANGE_CHK_EN
    // When NUM_OUT covers the whole select space no index can be out of range.
    if (NUM_OUT < (1 << SEL_W)) begin : g_range_chk
        assign err = en && ({1'b0, sel} >= (SEL_W + 1)'(NUM_OUT));
    end else begin : g_no_range_chk
        assign err = 1'b0;
    end
`endif

endmodule

// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - one-hot decoder with registered valid/ready output and 1-entry skid
// Ports: clk, rst_n (synchronous, active low), bus (decoder_pipe_if.slave).
// Optional feature macro: DEC_RANGE_CHK_EN adds out_err, carried alongside each beat.
module decoder_pipe
    import dec_pkg::*;
#(
    parameter int SEL_W   = DEC_SEL_W_DEF,
    parameter int NUM_OUT = DEC_NUM_OUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_pipe_if.slave  bus
);

    // A stored entry is the one-hot word, plus the error flag on top when enabled.
`ifdef DEC_RANGE_CHK_EN
    localparam int ENT_W = NUM_OUT + 1;
`else
    localparam int ENT_W = NUM_OUT;
`endif

    dec_occ_e           state_q, state_d;
    logic [ENT_W-1:0]   main_q, main_d;
    logic [ENT_W-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;

    logic [NUM_OUT-1:0] dec_onehot;
    logic [ENT_W-1:0]   dec_ent;
    logic               accept;
    logic               drain;
    logic               out_valid;

    onehot_dec #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .sel    (bus.in_sel),
        .en     (bus.in_en),
        .onehot (dec_onehot)
`ifdef DEC_RANGE_CHK_EN
        ,
        .err    (dec_ent[NUM_OUT])
`endif
    );

    assign dec_ent[NUM_OUT-1:0] = dec_onehot;

    assign out_valid = (state_q != DEC_EMPTY);
    assign accept    = bus.in_valid && in_ready_q;
    assign drain     = out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            DEC_EMPTY: begin
                if (accept) begin
                    main_d  = dec_ent;
                    state_d = DEC_ONE;
                end
            end
            DEC_ONE: begin
                if (accept && drain) begin
                    main_d  = dec_ent;
                end else if (accept) begin
                    skid_d  = dec_ent;
                    state_d = DEC_FULL;
                end else if (drain) begin
                    // Clear so the outputs read zero while nothing is valid.
                    main_d  = '0;
                    state_d = DEC_EMPTY;
                end
            end
            DEC_FULL: begin
                // in_ready_q is low here, so no beat can arrive this cycle.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = DEC_ONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = DEC_EMPTY;
            end
        endcase
        // Registered ready: look ahead one cycle so it drops as the skid fills.
        in_ready_d = (state_d != DEC_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= DEC_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_onehot = main_q[NUM_OUT-1:0];
`ifdef DEC_RANGE_CHK_EN
    assign bus.out_err    = main_q[NUM_OUT];
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - self-checking bench for decoder_pipe (3/8, 3/6 and 4/16 builds)
module tb_decoder_pipe;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    decoder_pipe_if #(.SEL_W(3), .NUM_OUT(8))  b8  ();
    decoder_pipe_if #(.SEL_W(3), .NUM_OUT(6))  b6  ();
    decoder_pipe_if #(.SEL_W(4), .NUM_OUT(16)) b16 ();

    decoder_pipe #(.SEL_W(3), .NUM_OUT(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    decoder_pipe #(.SEL_W(3), .NUM_OUT(6))  u_dut6  (.clk(clk), .rst_n(rst_n), .bus(b6));
    decoder_pipe #(.SEL_W(4), .NUM_OUT(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode for an N-output decoder: plain arithmetic on the rule.
    function automatic logic [32:0] ref_dec(input int sel, input logic en, input int n_out);
        logic [31:0] oh;
        logic        err;
        oh  = 32'd0;
        err = 1'b0;
        if (en) begin
            if (sel < n_out) oh = 32'd1 << sel;
            else             err = 1'b1;
        end
        return {err, oh};
    endfunction

    logic [32:0]  q[$];
    logic [32:0]  exp_ent;
    int           beats;
    logic         hold;
    logic [15:0]  prev_oh;
    int           r_sel;
    logic         r_en;

    initial begin
        rst_n = 1'b0;
        b8.in_valid  = 1'b0; b8.in_sel  = '0; b8.in_en  = 1'b0; b8.out_ready  = 1'b1;
        b6.in_valid  = 1'b0; b6.in_sel  = '0; b6.in_en  = 1'b0; b6.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in_sel = '0; b16.in_en = 1'b0; b16.out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",  32'(b8.out_valid), 32'd0);
        check("rst_onehot", 32'(b8.out_onehot), 32'd0);
        check("rst_ready",  32'(b8.in_ready), 32'd1);
        check("rst_ready16", 32'(b16.in_ready), 32'd1);
        rst_n = 1'b1;

        // Streaming at full rate: each beat appears one edge after it is offered.
        for (int i = 0; i < 8; i++) begin
            b8.in_valid = 1'b1; b8.in_sel = 3'(i); b8.in_en = 1'b1; b8.out_ready = 1'b1;
            tick();
            check("stream_valid",  32'(b8.out_valid), 32'd1);
            check("stream_onehot", 32'(b8.out_onehot), 32'd1 << i);
            check("stream_ready",  32'(b8.in_ready), 32'd1);
        end
        b8.in_valid = 1'b0;
        tick();
        check("stream_drain_valid",  32'(b8.out_valid), 32'd0);
        check("stream_drain_onehot", 32'(b8.out_onehot), 32'd0);

        // Backpressure: two beats fill main and skid.
        b8.out_ready = 1'b0;
        b8.in_valid = 1'b1; b8.in_sel = 3'd3; b8.in_en = 1'b1;
        tick();
        check("bp_ready_one", 32'(b8.in_ready), 32'd1);
        b8.in_sel = 3'd5;
        tick();
        b8.in_valid = 1'b0;
        check("bp_full_ready",  32'(b8.in_ready), 32'd0);
        check("bp_full_onehot", 32'(b8.out_onehot), 32'h08);
        tick();
        check("bp_hold_valid",  32'(b8.out_valid), 32'd1);
        check("bp_hold_onehot", 32'(b8.out_onehot), 32'h08);
        b8.out_ready = 1'b1;
        tick();
        check("bp_second_onehot", 32'(b8.out_onehot), 32'h20);
        check("bp_second_ready",  32'(b8.in_ready), 32'd1);
        tick();
        check("bp_empty_valid", 32'(b8.out_valid), 32'd0);

        // Disabled decode still produces a beat, carrying zero.
        b8.in_valid = 1'b1; b8.in_sel = 3'd6; b8.in_en = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        check("en0_valid",  32'(b8.out_valid), 32'd1);
        check("en0_onehot", 32'(b8.out_onehot), 32'd0);
        tick();

        // Reset mid-stream with the storage full and a handshake offered.
        b8.out_ready = 1'b0;
        b8.in_valid = 1'b1; b8.in_en = 1'b1; b8.in_sel = 3'd1;
        tick();
        b8.in_sel = 3'd2;
        tick();
        rst_n = 1'b0;
        b8.out_ready = 1'b1;
        tick();
        tick();
        check("midrst_valid",  32'(b8.out_valid), 32'd0);
        check("midrst_onehot", 32'(b8.out_onehot), 32'd0);
        check("midrst_ready",  32'(b8.in_ready), 32'd1);
        rst_n = 1'b1;
        b8.in_valid = 1'b0;
        tick();
        check("midrst_after_valid", 32'(b8.out_valid), 32'd0);

        // Out-of-range select on the 6-output build.
        b6.in_valid = 1'b1; b6.in_sel = 3'd7; b6.in_en = 1'b1; b6.out_ready = 1'b1;
        tick();
        check("range_hi_valid",  32'(b6.out_valid), 32'd1);
        check("range_hi_onehot", 32'(b6.out_onehot), 32'd0);
`ifdef DEC_RANGE_CHK_EN
        check("range_hi_err", 32'(b6.out_err), 32'd1);
`endif
        b6.in_sel = 3'd5;
        tick();
        b6.in_valid = 1'b0;
        check("range_top_onehot", 32'(b6.out_onehot), 32'h20);
`ifdef DEC_RANGE_CHK_EN
        check("range_top_err", 32'(b6.out_err), 32'd0);
`endif
        tick();
        check("range_drain_valid", 32'(b6.out_valid), 32'd0);

        // Random traffic on the 4/16 build against an occupancy/scoreboard model.
        beats = 0;
        hold  = 1'b0;
        prev_oh = '0;
        for (int cyc = 0; cyc < 60000 && beats < 10000; cyc++) begin
            check("rnd_ready",   32'(b16.in_ready), 32'(q.size() < 2));
            check("rnd_valid",   32'(b16.out_valid), 32'(q.size() != 0));
            check("rnd_onehot0", 32'($onehot0(b16.out_onehot)), 32'd1);
            if (!b16.out_valid) check("rnd_zero", 32'(b16.out_onehot), 32'd0);
            if (hold) begin
                check("rnd_hold_valid",  32'(b16.out_valid), 32'd1);
                check("rnd_hold_onehot", 32'(b16.out_onehot), 32'(prev_oh));
            end

            r_sel = int'($urandom_range(0, 15));
            r_en  = ($urandom_range(0, 7) != 0);
            b16.in_valid  = ($urandom_range(0, 3) != 0);
            b16.in_sel    = 4'(r_sel);
            b16.in_en     = r_en;
            b16.out_ready = ($urandom_range(0, 3) != 0);

            if (b16.out_valid && b16.out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_extra_beat", 32'd1, 32'd0);
                end else begin
                    exp_ent = q.pop_front();
                    check("rnd_data", 32'(b16.out_onehot), exp_ent[31:0]);
`ifdef DEC_RANGE_CHK_EN
                    check("rnd_err", 32'(b16.out_err), 32'(exp_ent[32]));
`endif
                    beats++;
                end
            end
            if (b16.in_valid && b16.in_ready) q.push_back(ref_dec(r_sel, r_en, 16));

            hold    = b16.out_valid && !b16.out_ready;
            prev_oh = b16.out_onehot;
            tick();
        end
        check("rnd_beat_count", 32'(beats >= 10000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
